// File: rtl/hazard_fwd_ctrl_pkg.sv
// Shared encodings for the EX forwarding / load-use interlock controller.
package hazard_fwd_ctrl_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // Wide enough for a bubble countdown of LOAD_LAT-1 with LOAD_LAT <= 3.
    localparam int unsigned BCNT_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        ILOCK = 1'b1
    } state_e;

endpackage

// File: rtl/fwd_sel_unit.sv
// Forward-mux select for one EX-stage source operand; EX/MEM wins over MEM/WB.
module fwd_sel_unit
    import hazard_fwd_ctrl_pkg::*;
#(
    parameter int unsigned RA_W = 5
) (
    input  logic [RA_W-1:0] id_ex_rs,
    input  logic            ex_mem_regw,
    input  logic [RA_W-1:0] ex_mem_rd,
    input  logic            mem_wb_regw,
    input  logic [RA_W-1:0] mem_wb_rd,
    output logic [1:0]      fwd_sel
);

    always_comb begin
        fwd_sel = FWD_RF;
        if (ex_mem_regw && (ex_mem_rd != '0) && (ex_mem_rd == id_ex_rs))
            fwd_sel = FWD_MEM;
        else if (mem_wb_regw && (mem_wb_rd != '0) && (mem_wb_rd == id_ex_rs))
            fwd_sel = FWD_WB;
    end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Operand forwarding, load-use interlock with configurable bubble count,
// data-memory wait freeze and saturating stall/forward counters.
module hazard_fwd_ctrl
    import hazard_fwd_ctrl_pkg::*;
#(
    parameter int unsigned RA_W     = 5,
    parameter int unsigned NUM_SRC  = 2,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_SRC*RA_W-1:0] if_id_rs,
    input  logic [NUM_SRC*RA_W-1:0] id_ex_rs,
    input  logic                    id_ex_memread,
    input  logic [RA_W-1:0]         id_ex_rd,
    input  logic                    ex_mem_regw,
    input  logic [RA_W-1:0]         ex_mem_rd,
    input  logic                    mem_wb_regw,
    input  logic [RA_W-1:0]         mem_wb_rd,
    input  logic                    dmem_wait,
    output logic [NUM_SRC*2-1:0]    fwd_sel,
    output logic                    stall_pc,
    output logic                    stall_if_id,
    output logic                    bubble_id_ex,
    output logic                    freeze_all,
    output logic [CNT_W-1:0]        stall_cnt,
    output logic [CNT_W-1:0]        fwd_cnt
);

    state_e              state_q, state_d;
    logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
    logic [CNT_W-1:0]    stall_cnt_q, fwd_cnt_q;
    logic                haz;
    logic                stall_c, bubble_c, freeze_c;

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_fwd
        fwd_sel_unit #(.RA_W(RA_W)) u_fwd (
            .id_ex_rs    (id_ex_rs[k*RA_W +: RA_W]),
            .ex_mem_regw (ex_mem_regw),
            .ex_mem_rd   (ex_mem_rd),
            .mem_wb_regw (mem_wb_regw),
            .mem_wb_rd   (mem_wb_rd),
            .fwd_sel     (fwd_sel[k*2 +: 2])
        );
    end

    always_comb begin
        haz = 1'b0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            if (id_ex_rd == if_id_rs[k*RA_W +: RA_W])
                haz = 1'b1;
        end
        haz = haz & id_ex_memread & (id_ex_rd != '0);
    end

    // Memory wait overrides everything: state and countdown hold, no bubble.
    always_comb begin
        state_d  = state_q;
        bcnt_d   = bcnt_q;
        stall_c  = 1'b0;
        bubble_c = 1'b0;
        freeze_c = 1'b0;
        if (dmem_wait) begin
            freeze_c = 1'b1;
            stall_c  = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (haz) begin
                        stall_c  = 1'b1;
                        bubble_c = 1'b1;
                        if (LOAD_LAT > 1) begin
                            state_d = ILOCK;
                            bcnt_d  = BCNT_W'(LOAD_LAT - 1);
                        end
                    end
                end
                ILOCK: begin
                    stall_c  = 1'b1;
                    bubble_c = 1'b1;
                    bcnt_d   = bcnt_q - 1'b1;
                    if (bcnt_q == BCNT_W'(1))
                        state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Gated by rst_n so a reset mid-interlock drops the stalls immediately.
    assign stall_pc     = stall_c  & rst_n;
    assign stall_if_id  = stall_c  & rst_n;
    assign bubble_id_ex = bubble_c & rst_n;
    assign freeze_all   = freeze_c & rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bcnt_q      <= '0;
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            if (stall_c && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + 1'b1;
            if ((fwd_sel != '0) && !dmem_wait && (fwd_cnt_q != '1))
                fwd_cnt_q <= fwd_cnt_q + 1'b1;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign fwd_cnt   = fwd_cnt_q;

endmodule
